// File: rtl/inst_axi_pkg.sv
// Shared types and constants for the instruction-fetch AXI read bridge.
// Optional rresp checking is enabled by defining INST_AXI_RRESP_CHK_EN.
package inst_axi_pkg;

  typedef enum logic {
    AR_IDLE = 1'b0,
    AR_BUSY = 1'b1
  } ar_state_e;

  localparam logic [1:0]  AXI_BURST_INCR      = 2'b01;
  localparam logic [7:0]  AXI_LEN_SINGLE      = 8'd0;
  localparam logic [1:0]  AXI_RESP_OKAY       = 2'b00;
  localparam logic [31:0] INST_NOP            = 32'h0340_0000;
  localparam int          MAX_OUTSTANDING_MIN = 1;
  localparam int          MAX_OUTSTANDING_MAX = 3;

  // SRAM-style size code (0/1/2 -> 1/2/4 bytes) maps directly onto AXI arsize.
  function automatic logic [2:0] arsize_of(input logic [1:0] size);
    return {1'b0, size};
  endfunction

endpackage

// File: rtl/inst_axi_outstanding_ctr.sv
// Saturating up/down counter tracking accepted-but-unreturned fetches.
module inst_axi_outstanding_ctr
  import inst_axi_pkg::*;
#(
  parameter int MAX = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       inc,
  input  logic       dec,
  output logic [1:0] cnt,
  output logic       full
);

  localparam logic [1:0] MAX_CNT = 2'(MAX);

  // Simultaneous inc and dec cancel; both directions saturate.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= 2'd0;
    end else if (inc && !dec && (cnt != MAX_CNT)) begin
      cnt <= cnt + 2'd1;
    end else if (dec && !inc && (cnt != 2'd0)) begin
      cnt <= cnt - 2'd1;
    end else begin
      cnt <= cnt;
    end
  end

  assign full = (cnt == MAX_CNT);

endmodule

// File: rtl/inst_axi_rd_bridge.sv
// SRAM-like instruction port to single-ID AXI4 read bridge, in-order, single-beat reads.
// Define INST_AXI_RRESP_CHK_EN to replace error beats with a NOP and flag inst_bus_err.
module inst_axi_rd_bridge
  import inst_axi_pkg::*;
#(
  parameter logic [3:0] ARID            = 4'd0,
  parameter int         MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_sram_req,
  input  logic        inst_sram_wr,
  input  logic [1:0]  inst_sram_size,
  input  logic [31:0] inst_sram_addr,
  input  logic [3:0]  inst_sram_wstrb,
  input  logic [31:0] inst_sram_wdata,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic        inst_bus_err
);

  ar_state_e  state;
  logic [1:0] cnt;
  logic       full;
  logic       r_hs;

  assign arid    = ARID;
  assign arlen   = AXI_LEN_SINGLE;
  assign arburst = AXI_BURST_INCR;
  assign arlock  = 2'b00;
  assign arcache = 4'b0000;
  assign arprot  = 3'b000;

  // A full counter blocks acceptance even if a beat retires this cycle.
  assign inst_sram_addr_ok = inst_sram_req & (state == AR_IDLE) & !full & !reset;
  assign rready            = (cnt != 2'd0);
  assign r_hs              = rvalid & rready;
  assign inst_sram_data_ok = r_hs & !reset;

  inst_axi_outstanding_ctr #(
    .MAX (MAX_OUTSTANDING)
  ) u_ctr (
    .clk   (clk),
    .reset (reset),
    .inc   (inst_sram_addr_ok),
    .dec   (r_hs),
    .cnt   (cnt),
    .full  (full)
  );

  // AR channel FSM: one address in flight, held stable until arready.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= AR_IDLE;
      arvalid <= 1'b0;
      araddr  <= 32'd0;
      arsize  <= 3'd0;
    end else begin
      case (state)
        AR_IDLE: begin
          if (inst_sram_addr_ok) begin
            araddr  <= inst_sram_addr;
            arsize  <= arsize_of(inst_sram_size);
            arvalid <= 1'b1;
            state   <= AR_BUSY;
          end
        end
        AR_BUSY: begin
          if (arready) begin
            arvalid <= 1'b0;
            state   <= AR_IDLE;
          end
        end
        default: begin
          arvalid <= 1'b0;
          state   <= AR_IDLE;
        end
      endcase
    end
  end

`ifdef INST_AXI_RRESP_CHK_EN
  logic resp_err;
  logic unused_inputs;

  assign resp_err        = (rresp != AXI_RESP_OKAY);
  assign inst_sram_rdata = resp_err ? INST_NOP : rdata;
  assign unused_inputs   = &{1'b0, inst_sram_wr, inst_sram_wstrb, inst_sram_wdata, rid, rlast};

  // Sticky until reset: once the fetch path has seen a bad beat, keep reporting it.
  always_ff @(posedge clk) begin
    if (reset) begin
      inst_bus_err <= 1'b0;
    end else if (inst_sram_data_ok && resp_err) begin
      inst_bus_err <= 1'b1;
    end else begin
      inst_bus_err <= inst_bus_err;
    end
  end
`else
  logic unused_inputs;

  assign inst_sram_rdata = rdata;
  assign inst_bus_err    = 1'b0;
  assign unused_inputs   = &{1'b0, inst_sram_wr, inst_sram_wstrb, inst_sram_wdata, rid, rlast, rresp};
`endif

endmodule

// File: tb/tb_inst_axi_rd_bridge.sv
// Directed self-checking bench for inst_axi_rd_bridge (MAX_OUTSTANDING=2).
module tb_inst_axi_rd_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_sram_req;
  logic        inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [31:0] inst_sram_addr;
  logic [3:0]  inst_sram_wstrb;
  logic [31:0] inst_sram_wdata;
  logic        inst_sram_addr_ok;
  logic        inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  logic        inst_bus_err;

  int n_cmp  = 0;
  int n_fail = 0;
  int pulses;

  always #5 clk = ~clk;

  inst_axi_rd_bridge #(.ARID(4'd0), .MAX_OUTSTANDING(2)) dut (
    .clk(clk), .reset(reset),
    .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr),
    .inst_sram_size(inst_sram_size), .inst_sram_addr(inst_sram_addr),
    .inst_sram_wstrb(inst_sram_wstrb), .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
    .inst_sram_rdata(inst_sram_rdata),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .inst_bus_err(inst_bus_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Move to 1ns after the next rising edge; inputs change there, outputs are sampled 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; inst_sram_req = 1'b0; inst_sram_wr = 1'b0; inst_sram_size = 2'd2;
    inst_sram_addr = 32'd0; inst_sram_wstrb = 4'd0; inst_sram_wdata = 32'd0;
    arready = 1'b0; rid = 4'd0; rdata = 32'd0; rresp = 2'b00; rlast = 1'b1; rvalid = 1'b0;
    tick(); tick();
    inst_sram_req = 1'b1; #1;
    check("addr_ok_in_reset", {31'd0, inst_sram_addr_ok}, 32'd0);
    inst_sram_req = 1'b0;
    tick(); reset = 1'b0; #1;
    check("rst_arvalid", {31'd0, arvalid}, 32'd0);
    check("rst_araddr", araddr, 32'd0);
    check("rst_arsize", {29'd0, arsize}, 32'd0);
    check("rst_rready", {31'd0, rready}, 32'd0);
    check("rst_data_ok", {31'd0, inst_sram_data_ok}, 32'd0);
    check("rst_bus_err", {31'd0, inst_bus_err}, 32'd0);
    check("rst_cnt", {30'd0, dut.cnt}, 32'd0);
    check("const_ar", {arid, arlen, arburst, arlock, arcache, arprot, 9'd0},
          {4'd0, 8'd0, 2'b01, 2'd0, 4'd0, 3'd0, 9'd0});

    // Protocol error: stray rvalid with nothing outstanding.
    rvalid = 1'b1; rdata = 32'h1111_1111; #1;
    check("stray_data_ok", {31'd0, inst_sram_data_ok}, 32'd0);
    check("stray_rready", {31'd0, rready}, 32'd0);
    rvalid = 1'b0;

    // Single fetch.
    tick();
    inst_sram_req = 1'b1; inst_sram_addr = 32'h1C00_0000; inst_sram_size = 2'd2; arready = 1'b1; #1;
    check("single_addr_ok", {31'd0, inst_sram_addr_ok}, 32'd1);
    tick(); inst_sram_req = 1'b0; #1;
    check("single_arvalid", {31'd0, arvalid}, 32'd1);
    check("single_araddr", araddr, 32'h1C00_0000);
    check("single_arsize", {29'd0, arsize}, 32'd2);
    tick(); rvalid = 1'b1; rdata = 32'h0280_0404; #1;
    check("single_arvalid_drop", {31'd0, arvalid}, 32'd0);
    check("single_data_ok", {31'd0, inst_sram_data_ok}, 32'd1);
    check("single_rdata", inst_sram_rdata, 32'h0280_0404);
    tick(); rvalid = 1'b0; #1;
    check("single_cnt", {30'd0, dut.cnt}, 32'd0);

    // Outstanding limit with req held and no R beats.
    pulses = 0;
    inst_sram_req = 1'b1; inst_sram_addr = 32'h1C00_0004;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (inst_sram_addr_ok) pulses++;
      tick();
    end
    #1;
    check("limit_pulses", pulses, 32'd2);
    check("limit_addr_ok_low", {31'd0, inst_sram_addr_ok}, 32'd0);
    check("limit_cnt", {30'd0, dut.cnt}, 32'd2);
    rvalid = 1'b1; rdata = 32'hAAAA_0001; #1;
    check("limit_ret_data_ok", {31'd0, inst_sram_data_ok}, 32'd1);
    check("limit_no_same_cycle", {31'd0, inst_sram_addr_ok}, 32'd0);
    tick(); rvalid = 1'b0; #1;
    check("limit_reaccept", {31'd0, inst_sram_addr_ok}, 32'd1);
    tick(); inst_sram_req = 1'b0; rvalid = 1'b1; rdata = 32'hAAAA_0002; #1;
    check("drain1_data_ok", {31'd0, inst_sram_data_ok}, 32'd1);
    check("drain1_rdata", inst_sram_rdata, 32'hAAAA_0002);
    tick(); rdata = 32'hAAAA_0003; #1;
    check("drain2_data_ok", {31'd0, inst_sram_data_ok}, 32'd1);
    tick(); rvalid = 1'b0; #1;
    check("drain_cnt", {30'd0, dut.cnt}, 32'd0);

    // AR backpressure for 5 cycles.
    arready = 1'b0; inst_sram_req = 1'b1; inst_sram_addr = 32'h1C00_0040; #1;
    check("bp_addr_ok", {31'd0, inst_sram_addr_ok}, 32'd1);
    tick(); inst_sram_addr = 32'h1C00_0080;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_arvalid", {31'd0, arvalid}, 32'd1);
      check("bp_araddr", araddr, 32'h1C00_0040);
      check("bp_addr_ok_low", {31'd0, inst_sram_addr_ok}, 32'd0);
      tick();
    end
    inst_sram_req = 1'b0; arready = 1'b1;
    tick();

    // Simultaneous accept and return with cnt=1.
    inst_sram_req = 1'b1; inst_sram_addr = 32'h1C00_00C0; rvalid = 1'b1; rdata = 32'h0000_00C0; #1;
    check("sim_addr_ok", {31'd0, inst_sram_addr_ok}, 32'd1);
    check("sim_data_ok", {31'd0, inst_sram_data_ok}, 32'd1);
    tick(); inst_sram_req = 1'b0; rvalid = 1'b0; #1;
    check("sim_cnt", {30'd0, dut.cnt}, 32'd1);
    tick();

    // Reset mid-flight at cnt=2 with arvalid held.
    arready = 1'b0; inst_sram_req = 1'b1; inst_sram_addr = 32'h1C00_0100; #1;
    check("mid_addr_ok", {31'd0, inst_sram_addr_ok}, 32'd1);
    tick(); inst_sram_req = 1'b0; #1;
    check("mid_cnt2", {30'd0, dut.cnt}, 32'd2);
    check("mid_arvalid", {31'd0, arvalid}, 32'd1);
    reset = 1'b1;
    tick(); reset = 1'b0; #1;
    check("mid_rst_arvalid", {31'd0, arvalid}, 32'd0);
    check("mid_rst_rready", {31'd0, rready}, 32'd0);
    check("mid_rst_cnt", {30'd0, dut.cnt}, 32'd0);

    // Error response beat.
    arready = 1'b1; inst_sram_req = 1'b1; inst_sram_addr = 32'h1C00_0200;
    tick(); inst_sram_req = 1'b0;
    tick(); rvalid = 1'b1; rresp = 2'b10; rdata = 32'hDEAD_BEEF; #1;
    check("err_data_ok", {31'd0, inst_sram_data_ok}, 32'd1);
`ifdef INST_AXI_RRESP_CHK_EN
    check("err_rdata", inst_sram_rdata, 32'h0340_0000);
    check("err_flag_same_cycle", {31'd0, inst_bus_err}, 32'd0);
    tick(); rvalid = 1'b0; rresp = 2'b00; #1;
    check("err_flag_next", {31'd0, inst_bus_err}, 32'd1);
    tick(); #1;
    check("err_flag_sticky", {31'd0, inst_bus_err}, 32'd1);
`else
    check("err_rdata_pass", inst_sram_rdata, 32'hDEAD_BEEF);
    tick(); rvalid = 1'b0; rresp = 2'b00; #1;
    check("err_flag_tied", {31'd0, inst_bus_err}, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/inst_axi_rd_bridge.md
# inst_axi_rd_bridge

Read-only bridge between the IF stage's SRAM-like instruction port and a single-ID AXI4 read channel (AR/R). It sits directly upstream of the IF stage. It accepts fetch requests with `addr_ok`, issues single-beat AXI reads, and returns each instruction word with `data_ok` in request order. Up to `MAX_OUTSTANDING` fetches can be in flight.

## Interface
Parameters:
- `ARID`, default 4'd0: constant AXI read ID driven on `arid`.
- `MAX_OUTSTANDING`, default 2: maximum number of accepted but not yet returned fetches. Legal values are 1..3.

Ports:
- `clk`  in  1: clock.
- `reset`  in  1: reset, synchronous, active-high.
- `inst_sram_req`  in  1: fetch request.
- `inst_sram_wr`  in  1: ignored; every request is a read.
- `inst_sram_size`  in  2: 0, 1 or 2 → 1, 2 or 4 bytes.
- `inst_sram_addr`  in  32: fetch address.
- `inst_sram_wstrb`  in  4: ignored.
- `inst_sram_wdata`  in  32: ignored.
- `inst_sram_addr_ok`  out  1: request accepted this cycle.
- `inst_sram_data_ok`  out  1: `inst_sram_rdata` is valid this cycle.
- `inst_sram_rdata`  out  32: returned instruction word.
- `arid`  out  4: always equals `ARID`.
- `araddr`  out  32: read address.
- `arlen`  out  8: always 0.
- `arsize`  out  3: {1'b0, captured size}.
- `arburst`  out  2: always 2'b01 (INCR).
- `arlock`  out  2: always 0.
- `arcache`  out  4: always 0.
- `arprot`  out  3: always 0.
- `arvalid`  out  1: address channel valid.
- `arready`  in  1: address channel ready.
- `rid`  in  4: ignored.
- `rdata`  in  32: read data.
- `rresp`  in  2: read response.
- `rlast`  in  1: ignored; every read is a single beat.
- `rvalid`  in  1: read data valid.
- `rready`  out  1: read data ready.
- `inst_bus_err`  out  1: sticky bus-error flag (see Configuration).

## Operation
- Address-channel FSM with two states:
  - AR_IDLE: `arvalid`=0. When `inst_sram_addr_ok` is asserted, capture address and size into `araddr`/`arsize`, set `arvalid`=1, and go to AR_BUSY.
  - AR_BUSY: hold `arvalid`=1 with `araddr`/`arsize` stable. On `arready`, clear `arvalid` and return to AR_IDLE.
- `inst_sram_addr_ok` = `inst_sram_req` & (state==AR_IDLE) & (cnt < MAX_OUTSTANDING) & !reset.
- Outstanding counter `cnt` (2 bits):
  - +1 on `addr_ok`.
  - −1 on an R handshake (`rvalid` & `rready`).
  - When both happen in the same cycle, `cnt` is unchanged.
  - Never exceeds `MAX_OUTSTANDING` and never wraps below 0.
- `rready` = (cnt != 0). An `rvalid` while cnt==0 is a slave protocol error: it is not accepted and produces no `data_ok`.
- `inst_sram_data_ok` = `rvalid` & `rready` & !reset, combinational. `inst_sram_rdata` = `rdata`, combinational.
- Responses return in request order, which AXI guarantees because all reads use a single ID. No reorder buffer.
- The bridge never drops a response. Discarding stale instructions is the IF stage's job.

## Timing
- Reset values:
  - `arvalid`=0, `araddr`=0, `arsize`=0, cnt=0, FSM in AR_IDLE.
  - `rready`=0, `addr_ok`=0, `data_ok`=0, `inst_bus_err`=0.
- `arvalid` rises on the cycle after `addr_ok`.
- Best-case fetch latency is 2 cycles (`addr_ok` at T, AR handshake at T+1, `rvalid` at T+2 → `data_ok` at T+2).
- Throughput is at most one accepted request every 2 cycles, because `addr_ok` is blocked during AR_BUSY.
- When cnt==MAX_OUTSTANDING, a simultaneous R handshake does not unblock `addr_ok` in the same cycle. The request is accepted the following cycle.
- Reset asserted mid-transaction clears all state, including cnt and `arvalid`. The slave is reset by the same signal, so no drain is performed.

## Configuration
- `INST_AXI_RRESP_CHK_EN` defined:
  - On a beat with `rresp` != 2'b00, `inst_sram_rdata` is replaced by 32'h0340_0000 (NOP) and `data_ok` is still asserted.
  - `inst_bus_err` is set on the next edge and stays set until reset.
- `INST_AXI_RRESP_CHK_EN` undefined: `rresp` is ignored, `rdata` always passes through, and `inst_bus_err` is tied to 0.

## Structure
- Shared package `inst_axi_pkg` holds:
  - AR FSM state encoding.
  - AXI burst/size constants.
  - The NOP constant 32'h0340_0000.
  - `MAX_OUTSTANDING` bounds.
- One sub-module: `inst_axi_outstanding_ctr`, a saturating up/down counter with inc/dec inputs and a `full` output.

## Test plan
- Single fetch:
  - Stimulus: req addr=0x1C000000 size=2, `arready`=1, `rvalid` 1 cycle later with `rdata`=0x02800404.
  - Required: `addr_ok` at T, `arvalid` at T+1 with `araddr`=0x1C000000 and `arsize`=3'b010, `data_ok` at T+2 with `rdata`=0x02800404.
- Outstanding limit:
  - Stimulus: `MAX_OUTSTANDING`=2, req held continuously, `rvalid` withheld.
  - Required: exactly 2 `addr_ok` pulses, then `addr_ok`=0.
  - Then a single R beat is returned; required: `data_ok` on that cycle and `addr_ok` reasserted the next cycle.
- AR backpressure:
  - Stimulus: `arready`=0 for 5 cycles.
  - Required: `arvalid`=1 and `araddr` stable for all 5 cycles; `addr_ok`=0 for the same 5 cycles.
- Simultaneous accept/return:
  - Stimulus: cnt=1, `addr_ok` and an R handshake in the same cycle.
  - Required: cnt stays 1.
- Reset mid-flight:
  - Stimulus: cnt=2 with `arvalid`=1, then `reset` pulsed.
  - Required: the next cycle shows `arvalid`=0, `rready`=0, cnt=0.
- Error response (with `INST_AXI_RRESP_CHK_EN`):
  - Stimulus: `rresp`=2'b10 with `rdata`=0xDEADBEEF.
  - Required: `data_ok`=1, `rdata`=0x03400000, `inst_bus_err`=1 from the next cycle onward.
